piso_tx6: RTL
=============

Name: piso_tx6

Overview:
- Parallel-in/serial-out transmitter. It is the sending end for the 6-bit serial-in shift register (reg6bit).
- Accepts a WIDTH-bit word through a valid/ready load handshake.
- Shifts the word out one bit per Clock on SO, then returns to idle.
- Supports gapless back-to-back frames so a downstream serial-in register sees a continuous bit stream.

Parameters:
- WIDTH, 6, data bits per frame (legal range 2..16).
- MSB_FIRST, 1, 1 = Din[WIDTH-1] is sent first; 0 = Din[0] is sent first.

Ports:
- Clock  input  1  rising-edge clock.
- Resetn  input  1  asynchronous, active-low reset.
- Din  input  WIDTH  parallel word to transmit.
- Load  input  1  Din is valid; captured when Load && Ready at a rising edge.
- Ready  output  1  transmitter can accept a word this cycle.
- SO  output  1  serial data out, registered.
- Busy  output  1  a frame is in progress.
- Done  output  1  one-cycle pulse marking the final bit of a frame.

Behaviour:
- Reset: Clock is the only clock; Resetn is asynchronous active-low. While Resetn=0: state=IDLE, shift register=0, bit count=0, SO=0, Busy=0, Done=0, Ready=1.
- States:
  - IDLE: SO=0, Busy=0, Ready=1. Load=1 at an edge captures Din, sets count=0 and moves to SHIFT. Load=0 stays in IDLE.
  - SHIFT: Busy=1. SO shows the current bit. Each edge advances the shift register by one position (toward the MSB if MSB_FIRST, else toward the LSB, zero-filled) and increments count.
- Latency: the first bit appears on SO the cycle after the capture edge. Frame length is L = WIDTH, or WIDTH+1 with PARITY_EN. Bit k (k=0..L-1) is on SO during cycle k+1 after capture.
- Last bit (count == L-1): Done=1 and Ready=1 in that cycle.
  - Load=1 at the following edge: capture new Din, count=0, stay in SHIFT. The next frame follows with no gap.
  - Load=0: go to IDLE; SO=0 from the next cycle.
- Load while Ready=0 is ignored; Din is sampled only at the capture edge. Changes to Din mid-frame have no effect.
- Ready, Busy and Done are combinational decodes of the state and count registers. SO is driven directly from a register bit and is glitch-free.
- Count width is clog2(WIDTH+2); the counter never wraps inside a frame.
- Resetn asserted mid-frame aborts immediately: outputs take their reset values and the partial frame is discarded.

Optional Feature:
- Macro PIPO_TX_PARITY_EN.
- Defined: one even-parity bit (XOR of the captured Din) is appended after the data bits, so L = WIDTH+1. Done and Ready assert on the parity-bit cycle.
- Undefined: no parity logic, L = WIDTH, and port list unchanged.

Decomposition:
- Shared package/header `piso_defs`:
  - state encodings ST_IDLE=1'b0, ST_SHIFT=1'b1.
  - default WIDTH localparam.
  - function for frame length L.
- One sub-module, `frame_bit_counter`: loadable modulo counter with synchronous clear on capture and a terminal-count flag (count == L-1), async active-low reset.

Test Plan:
- Reset then idle (WIDTH=6, MSB_FIRST=1): hold Resetn=0 for 2 cycles, Load=0 -> SO=0, Ready=1, Busy=0, Done=0 throughout.
- Single frame: Din=6'b101101 with a 1-cycle Load pulse -> SO = 1,0,1,1,0,1 over the next 6 cycles. Done=1 only in cycle 6, Busy=0 in cycle 7. Loopback into reg6bit gives A=6'b101101 after the 6th shift.
- Back-to-back frames: Din=6'b110000, then Load held with Din=6'b000111 while Ready=1 in the last-bit cycle -> 12 contiguous bits 110000000111, two Done pulses 6 cycles apart.
- Busy rejection and LSB-first: Load asserted in cycles 2-4 of a frame with Din=6'b111111 -> ignored, original bits unaltered. MSB_FIRST=0 with Din=6'b000011 -> SO = 1,1,0,0,0,0.
- Mid-frame reset: Resetn pulled low in cycle 3 of a frame -> SO=0 and Ready=1 immediately (asynchronously), no Done. A fresh load then transmits a full frame correctly.
- Parity (PIPO_TX_PARITY_EN defined): Din=6'b101100 -> SO = 1,0,1,1,0,0,1. Done in cycle 7, Ready=1 in cycle 7.

Source files
------------

// File: rtl/piso_defs.sv
//------------------------------------------------------------------------------
// Module  : piso_defs (package)
// Brief   : Shared state encoding, default width and frame-length helper for
//           piso_tx6. Optional macro: PIPO_TX_PARITY_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package piso_defs;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_e;

   localparam int DEF_WIDTH = 6;

   function automatic int frame_len(input int width);
`ifdef PIPO_TX_PARITY_EN
      return width + 1;
`else
      return width;
`endif
   endfunction

endpackage

`default_nettype wire

// File: rtl/frame_bit_counter.sv
//------------------------------------------------------------------------------
// Module  : frame_bit_counter
// Brief   : Modulo bit counter, cleared on frame capture, with terminal flag.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module frame_bit_counter #(
   parameter int CNT_W = 3,
   parameter int LAST  = 5
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             tc_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign tc_o  = (cnt_q == CNT_W'(LAST));
   assign cnt_o = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = tc_o ? '0 : cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/piso_tx6.sv
//------------------------------------------------------------------------------
// Module  : piso_tx6
// Brief   : Parallel-in/serial-out transmitter with valid/ready load and
//           gapless back-to-back frames. Optional macro: PIPO_TX_PARITY_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module piso_tx6
   import piso_defs::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             Clock,
   input  logic             Resetn,
   input  logic [WIDTH-1:0] Din,
   input  logic             Load,
   output logic             Ready,
   output logic             SO,
   output logic             Busy,
   output logic             Done
);

   localparam int L     = frame_len(WIDTH);
   localparam int CNT_W = $clog2(WIDTH + 2);

   state_e           state_q, state_d;
   logic [L-1:0]     shreg_q, shreg_d;
   logic [L-1:0]     frame_w, shift_w;
   logic [CNT_W-1:0] cnt_w;
   logic             tc_w, busy_w, ready_w, capture_w;

   // The shift register always drains to zero, so SO idles low with no mux.
   generate
      if (MSB_FIRST) begin : g_msb_first
`ifdef PIPO_TX_PARITY_EN
         assign frame_w = {Din, ^Din};
`else
         assign frame_w = Din;
`endif
         assign shift_w = {shreg_q[L-2:0], 1'b0};
         assign SO      = shreg_q[L-1];
      end else begin : g_lsb_first
`ifdef PIPO_TX_PARITY_EN
         assign frame_w = {^Din, Din};
`else
         assign frame_w = Din;
`endif
         assign shift_w = {1'b0, shreg_q[L-1:1]};
         assign SO      = shreg_q[0];
      end
   endgenerate

   assign busy_w    = (state_q == ST_SHIFT);
   assign ready_w   = !busy_w || tc_w;
   assign capture_w = Load && ready_w;

   assign Busy  = busy_w;
   assign Ready = ready_w;
   assign Done  = busy_w && tc_w;

   frame_bit_counter #(
      .CNT_W (CNT_W),
      .LAST  (L - 1)
   ) u_cnt (
      .clk_i  (Clock),
      .rst_ni (Resetn),
      .clr_i  (capture_w),
      .en_i   (busy_w),
      .cnt_o  (cnt_w),
      .tc_o   (tc_w)
   );

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      case (state_q)
         ST_IDLE: begin
            if (capture_w) begin
               state_d = ST_SHIFT;
               shreg_d = frame_w;
            end
         end
         ST_SHIFT: begin
            if (capture_w) begin
               shreg_d = frame_w;
            end else begin
               shreg_d = shift_w;
               if (tc_w) begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            shreg_d = '0;
         end
      endcase
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q <= ST_IDLE;
         shreg_q <= '0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
      end
   end

   logic unused_w;
   assign unused_w = ^cnt_w;

endmodule

`default_nettype wire
